// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO interrupt controller: width, trigger
// encodings, controller states and the per-pin event decoder.
package gpio_pkg;

  localparam int GPIO_WIDTH = 32;

  typedef enum logic [1:0] {
    TRIG_LEVEL_HIGH = 2'b00,
    TRIG_LEVEL_LOW  = 2'b01,
    TRIG_RISE       = 2'b10,
    TRIG_FALL       = 2'b11
  } trig_type_e;

  typedef enum logic [1:0] {
    ST_RESET  = 2'b00,
    ST_WARMUP = 2'b01,
    ST_ACTIVE = 2'b10
  } ctrl_state_e;

  // nxt is the first-stage value, cur the value currently presented as gpio_sync.
  function automatic logic trig_event(trig_type_e ttype, logic nxt, logic cur);
    logic ev;
    ev = 1'b0;
    case (ttype)
      TRIG_LEVEL_HIGH: ev = nxt;
      TRIG_LEVEL_LOW:  ev = ~nxt;
      TRIG_RISE:       ev = nxt & ~cur;
      TRIG_FALL:       ev = ~nxt & cur;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/gpio_sync2.sv
// Two-flop synchronizer for asynchronous pad inputs; exposes the first
// stage so the controller can see the value about to enter gpio_sync.
module gpio_sync2
  import gpio_pkg::*;
#(
  parameter int WIDTH = GPIO_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] s1_o,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    s1_d   = din;
    sync_d = s1_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q   <= '0;
      sync_q <= '0;
    end else begin
      s1_q   <= s1_d;
      sync_q <= sync_d;
    end
  end

  assign s1_o   = s1_q;
  assign sync_o = sync_q;

endmodule

// File: rtl/gpio_int_ctrl.sv
// GPIO interrupt controller: synchronizes pads, detects per-pin level/edge
// events after a short warmup, and keeps sticky read-to-clear status.
module gpio_int_ctrl
  import gpio_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  input  logic [GPIO_WIDTH-1:0] gpio_dir,
  input  logic [GPIO_WIDTH-1:0] int_en,
  input  logic [GPIO_WIDTH-1:0] int_type0,
  input  logic [GPIO_WIDTH-1:0] int_type1,
  input  logic                  status_rd,
  output logic [GPIO_WIDTH-1:0] gpio_sync,
  output logic [GPIO_WIDTH-1:0] int_status,
  output logic                  interrupt
);

  logic [GPIO_WIDTH-1:0] s1;
  logic [GPIO_WIDTH-1:0] pin_event;
  logic [GPIO_WIDTH-1:0] set_raw;
  logic [GPIO_WIDTH-1:0] set_eff;
  logic [GPIO_WIDTH-1:0] int_status_q, int_status_d;
  logic                  interrupt_q, interrupt_d;
  ctrl_state_e           state_q, state_d;
  logic [1:0]            warm_cnt_q, warm_cnt_d;
  logic                  active;

  gpio_sync2 #(
    .WIDTH(GPIO_WIDTH)
  ) u_sync2 (
    .clock  (clock),
    .reset  (reset),
    .din    (gpio_in),
    .s1_o   (s1),
    .sync_o (gpio_sync)
  );

  // Warmup lets the synchronizer flush its reset zeros before events count.
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    case (state_q)
      ST_RESET: begin
        state_d    = ST_WARMUP;
        warm_cnt_d = 2'd0;
      end
      ST_WARMUP: begin
        if (warm_cnt_q == 2'd1) begin
          state_d    = ST_ACTIVE;
          warm_cnt_d = 2'd0;
        end else begin
          warm_cnt_d = warm_cnt_q + 2'd1;
        end
      end
      ST_ACTIVE: state_d = ST_ACTIVE;
      default:   state_d = ST_RESET;
    endcase
  end

  assign active = (state_q == ST_ACTIVE);

  always_comb begin
    pin_event = '0;
    for (int i = 0; i < GPIO_WIDTH; i++) begin
      pin_event[i] = trig_event(trig_type_e'({int_type1[i], int_type0[i]}), s1[i], gpio_sync[i]);
    end
  end

  // A read clears level-triggered bits for one cycle so software sees the
  // re-assertion; edge bits arriving on the read edge survive it.
  always_comb begin
    set_raw      = pin_event & int_en & ~gpio_dir & {GPIO_WIDTH{active}};
    set_eff      = set_raw & ~(~int_type1 & {GPIO_WIDTH{status_rd}});
    int_status_d = status_rd ? set_eff : (int_status_q | set_eff);
    interrupt_d  = |int_status_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RESET;
      warm_cnt_q   <= 2'd0;
      int_status_q <= '0;
      interrupt_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      warm_cnt_q   <= warm_cnt_d;
      int_status_q <= int_status_d;
      interrupt_q  <= interrupt_d;
    end
  end

  assign int_status = int_status_q;
  assign interrupt  = interrupt_q;

endmodule

// File: tb/tb_gpio_int_ctrl.sv
// Table-driven bench for gpio_int_ctrl with a scoreboard of expected outputs
// and hand-written reset sequences.
module tb_gpio_int_ctrl;

  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  logic        clock;
  logic        reset;
  logic [31:0] gpio_in, gpio_dir, int_en, int_type0, int_type1;
  logic        status_rd;
  logic [31:0] gpio_sync, int_status;
  logic        interrupt;

  typedef struct {
    logic [31:0] in_v;
    logic [31:0] dir_v;
    logic [31:0] en_v;
    logic [31:0] t1_v;
    logic [31:0] t0_v;
    logic        rd_v;
    logic [31:0] x_sync;
    logic [31:0] x_stat;
    logic        x_irq;
  } vec_t;

  typedef struct {
    logic [31:0] x_sync;
    logic [31:0] x_stat;
    logic        x_irq;
    int          idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  gpio_int_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .gpio_in    (gpio_in),
    .gpio_dir   (gpio_dir),
    .int_en     (int_en),
    .int_type0  (int_type0),
    .int_type1  (int_type1),
    .status_rd  (status_rd),
    .gpio_sync  (gpio_sync),
    .int_status (int_status),
    .interrupt  (interrupt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(logic [31:0] in_v, logic [31:0] dir_v, logic [31:0] en_v,
                              logic [31:0] t1_v, logic [31:0] t0_v, logic rd_v,
                              logic [31:0] xs, logic [31:0] xst, logic xi);
    vec_t v;
    v.in_v = in_v; v.dir_v = dir_v; v.en_v = en_v; v.t1_v = t1_v; v.t0_v = t0_v;
    v.rd_v = rd_v; v.x_sync = xs; v.x_stat = xst; v.x_irq = xi;
    vecs.push_back(v);
  endfunction

  task automatic run_table(string tag);
    exp_t e;
    exp_t x;
    for (int i = 0; i < vecs.size(); i++) begin
      gpio_in   = vecs[i].in_v;
      gpio_dir  = vecs[i].dir_v;
      int_en    = vecs[i].en_v;
      int_type1 = vecs[i].t1_v;
      int_type0 = vecs[i].t0_v;
      status_rd = vecs[i].rd_v;
      e.x_sync = vecs[i].x_sync;
      e.x_stat = vecs[i].x_stat;
      e.x_irq  = vecs[i].x_irq;
      e.idx    = i;
      sb.push_back(e);
      @(posedge clock);
      @(negedge clock);
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL %s scoreboard empty at vector %0d", tag, i);
      end else begin
        x = sb.pop_front();
        chk($sformatf("%s[%0d] gpio_sync", tag, x.idx), gpio_sync, x.x_sync);
        chk($sformatf("%s[%0d] int_status", tag, x.idx), int_status, x.x_stat);
        chk($sformatf("%s[%0d] interrupt", tag, x.idx), {31'd0, interrupt}, {31'd0, x.x_irq});
      end
    end
    vecs.delete();
  endtask

  initial begin
    reset     = 1'b0;
    gpio_in   = ALL;
    gpio_dir  = '0;
    int_en    = ALL;
    int_type1 = ALL;
    int_type0 = '0;
    status_rd = 1'b0;

    // Held in reset with the clock running: everything stays cleared.
    repeat (3) begin
      @(negedge clock);
      chk("reset gpio_sync", gpio_sync, 32'h0);
      chk("reset int_status", int_status, 32'h0);
      chk("reset interrupt", {31'd0, interrupt}, 32'h0);
    end
    reset = 1'b1;

    // Startup with all pins high, rising-edge, enabled: nothing may fire.
    //   in     dir    en      t1     t0     rd  sync   status irq
    add(ALL,   0,     ALL,    ALL,   0,     0,  0,     0,     0);
    add(ALL,   0,     ALL,    ALL,   0,     0,  ALL,   0,     0);
    add(ALL,   0,     ALL,    ALL,   0,     0,  ALL,   0,     0);
    add(ALL,   0,     ALL,    ALL,   0,     0,  ALL,   0,     0);
    add(ALL,   0,     ALL,    ALL,   0,     0,  ALL,   0,     0);
    add(0,     0,     ALL,    ALL,   0,     0,  ALL,   0,     0);
    add(0,     0,     ALL,    ALL,   0,     0,  0,     0,     0);
    add(0,     0,     ALL,    ALL,   0,     0,  0,     0,     0);
    // Rising edge on pin 3
    add('h08,  0,     'h28,   ALL,   0,     0,  0,     0,     0);
    add('h08,  0,     'h28,   ALL,   0,     0,  'h08,  'h08,  0);
    add('h08,  0,     'h28,   ALL,   0,     0,  'h08,  'h08,  1);
    // Pin 5 rises on the reading edge: set wins
    add('h28,  0,     'h28,   ALL,   0,     0,  'h08,  'h08,  1);
    add('h28,  0,     'h28,   ALL,   0,     1,  'h28,  'h20,  1);
    add('h28,  0,     'h28,   ALL,   0,     0,  'h28,  'h20,  1);
    add('h28,  0,     'h28,   ALL,   0,     1,  'h28,  0,     1);
    add('h28,  0,     'h28,   ALL,   0,     0,  'h28,  0,     0);
    // Pin 7 rises as an output, then with its enable off
    add('hA8,  'h80,  'hA8,   ALL,   0,     0,  'h28,  0,     0);
    add('hA8,  'h80,  'hA8,   ALL,   0,     0,  'hA8,  0,     0);
    add('hA8,  'h80,  'hA8,   ALL,   0,     0,  'hA8,  0,     0);
    add('h28,  'h80,  'hA8,   ALL,   0,     0,  'hA8,  0,     0);
    add('h28,  'h80,  'hA8,   ALL,   0,     0,  'h28,  0,     0);
    add('hA8,  0,     'h28,   ALL,   0,     0,  'h28,  0,     0);
    add('hA8,  0,     'h28,   ALL,   0,     0,  'hA8,  0,     0);
    add('hA8,  0,     'h28,   ALL,   0,     0,  'hA8,  0,     0);
    // Level-high pin 0: read clears for one cycle, then re-sets
    add('hA9,  0,     'h01,   ~32'h1, 0,    0,  'hA8,  0,     0);
    add('hA9,  0,     'h01,   ~32'h1, 0,    0,  'hA9,  'h01,  0);
    add('hA9,  0,     'h01,   ~32'h1, 0,    0,  'hA9,  'h01,  1);
    add('hA9,  0,     'h01,   ~32'h1, 0,    1,  'hA9,  0,     1);
    add('hA9,  0,     'h01,   ~32'h1, 0,    0,  'hA9,  'h01,  0);
    add('hA9,  0,     'h01,   ~32'h1, 0,    0,  'hA9,  'h01,  1);
    // Sticky across enable/direction changes until read
    add('hA9,  0,     0,      ~32'h1, 0,    0,  'hA9,  'h01,  1);
    add('hA9,  'h01,  0,      ~32'h1, 0,    0,  'hA9,  'h01,  1);
    add('hA9,  'h01,  0,      ~32'h1, 0,    1,  'hA9,  0,     1);
    add('hA9,  0,     0,      ~32'h1, 0,    0,  'hA9,  0,     0);
    // Level-low pin 4
    add('hA9,  0,     'h10,   0,     'h10,  0,  'hA9,  'h10,  0);
    add('hA9,  0,     'h10,   0,     'h10,  0,  'hA9,  'h10,  1);
    add('hA9,  0,     'h10,   0,     'h10,  1,  'hA9,  0,     1);
    add('hA9,  0,     'h10,   0,     'h10,  0,  'hA9,  'h10,  0);
    add('hAD,  0,     0,      0,     'h10,  1,  'hA9,  0,     1);
    add('hAD,  0,     0,      0,     'h10,  0,  'hAD,  0,     0);
    // Falling edge on pin 2
    add('hA9,  0,     'h04,   'h04,  'h04,  0,  'hAD,  0,     0);
    add('hA9,  0,     'h04,   'h04,  'h04,  0,  'hA9,  'h04,  0);
    add('hA9,  0,     'h04,   'h04,  'h04,  0,  'hA9,  'h04,  1);
    // Level-high on pins 0..7 builds status up to 0xFF
    add('hFF,  0,     'hFF,   0,     0,     0,  'hA9,  'hAD,  1);
    add('hFF,  0,     'hFF,   0,     0,     0,  'hFF,  'hFF,  1);
    add('hFF,  0,     'hFF,   0,     0,     0,  'hFF,  'hFF,  1);
    run_table("func");

    // Asynchronous reset mid-operation, checked between clock edges.
    #2 reset = 1'b0;
    #1;
    chk("async int_status", int_status, 32'h0);
    chk("async interrupt", {31'd0, interrupt}, 32'h0);
    chk("async gpio_sync", gpio_sync, 32'h0);
    @(negedge clock);
    chk("held int_status", int_status, 32'h0);
    chk("held interrupt", {31'd0, interrupt}, 32'h0);
    reset = 1'b1;

    // Warmup length: level-high pins asserted first counts on the fourth edge.
    add('hFF,  0,     'hFF,   0,     0,     0,  0,     0,     0);
    add('hFF,  0,     'hFF,   0,     0,     0,  'hFF,  0,     0);
    add('hFF,  0,     'hFF,   0,     0,     0,  'hFF,  0,     0);
    add('hFF,  0,     'hFF,   0,     0,     0,  'hFF,  'hFF,  0);
    add('hFF,  0,     'hFF,   0,     0,     0,  'hFF,  'hFF,  1);
    run_table("warm");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
